chacha20_cfg_sequencer: RTL and testbench

Sequences loading of key, nonce and block counter into the chacha20 core through the core's AXI write-slave configuration port. It accepts one 384-bit configuration per valid/ready handshake and issues six single-beat AXI writes. It then raises init_data_finish and watches outdate_key for the rekey condition. It also reports write errors and response timeouts to the host.

---
 rtl/chacha20_cfg_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_chacha20_cfg_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chacha20_cfg_sequencer.sv
// Loads key, nonce and block counter into the chacha20 core as six single-beat AXI writes.
// It then keeps the core running and reports key exhaustion, bus errors and handshake timeouts.
module chacha20_cfg_sequencer #(
    parameter int AXI_IDWIDTH = 4,
    parameter int CFG_ID      = 0,
    parameter int TIMEOUT     = 255
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [255:0]           cfg_key,
    input  logic [95:0]            cfg_nonce,
    input  logic [31:0]            cfg_counter,
    output logic                   m_axi_awvalid,
    input  logic                   m_axi_awready,
    output logic [63:0]            m_axi_awaddr,
    output logic [7:0]             m_axi_awlen,
    output logic [AXI_IDWIDTH-1:0] m_axi_awid,
    output logic                   m_axi_wvalid,
    input  logic                   m_axi_wready,
    output logic                   m_axi_wlast,
    output logic [63:0]            m_axi_wdata,
    input  logic                   m_axi_bvalid,
    output logic                   m_axi_bready,
    input  logic [AXI_IDWIDTH-1:0] m_axi_bid,
    input  logic [1:0]             m_axi_bresp,
    output logic                   init_data_finish,
    input  logic                   outdate_key,
    output logic                   key_stale,
    output logic                   cfg_err,
    output logic [1:0]             err_code
);
    typedef enum logic [2:0] {IDLE, AW, W, B, RUN, ERR} state_t;

    localparam logic [7:0]             TIMER_MAX = 8'(TIMEOUT);
    localparam logic [AXI_IDWIDTH-1:0] ID        = AXI_IDWIDTH'(CFG_ID);

    state_t       state, state_next;
    logic [255:0] key_r;
    logic [95:0]  nonce_r;
    logic [31:0]  counter_r;
    logic [2:0]   beat;
    logic [7:0]   timer;
    logic         ready_state, busy, accept, handshake, timed_out;
    logic         beat_ok, last_ok, err_hit;
    logic [1:0]   err_next;
    logic [63:0]  beat_data;

    always_comb begin
        ready_state = (state == IDLE) || (state == RUN) || (state == ERR);
        busy        = (state == AW) || (state == W) || (state == B);
        accept      = ready_state && cfg_valid;
        handshake   = 1'b0;
        case (state)
            AW:      handshake = m_axi_awready;
            W:       handshake = m_axi_wready;
            B:       handshake = m_axi_bvalid;
            default: handshake = 1'b0;
        endcase
        // A handshake arriving in the same cycle the timer expires takes priority.
        timed_out  = busy && !handshake && (timer == TIMER_MAX);
        state_next = state;
        err_hit    = 1'b0;
        err_next   = 2'd0;
        beat_ok    = 1'b0;
        last_ok    = 1'b0;
        if (accept) begin
            state_next = AW;
        end else begin
            case (state)
                AW: begin
                    if (handshake) begin
                        state_next = W;
                    end else if (timed_out) begin
                        state_next = ERR;
                        err_hit    = 1'b1;
                        err_next   = 2'd3;
                    end
                end
                W: begin
                    if (handshake) begin
                        state_next = B;
                    end else if (timed_out) begin
                        state_next = ERR;
                        err_hit    = 1'b1;
                        err_next   = 2'd3;
                    end
                end
                B: begin
                    if (handshake) begin
                        if (m_axi_bresp != 2'b00) begin
                            state_next = ERR;
                            err_hit    = 1'b1;
                            err_next   = 2'd1;
                        end else if (m_axi_bid != ID) begin
                            state_next = ERR;
                            err_hit    = 1'b1;
                            err_next   = 2'd2;
                        end else if (beat == 3'd5) begin
                            state_next = RUN;
                            last_ok    = 1'b1;
                        end else begin
                            state_next = AW;
                            beat_ok    = 1'b1;
                        end
                    end else if (timed_out) begin
                        state_next = ERR;
                        err_hit    = 1'b1;
                        err_next   = 2'd3;
                    end
                end
                RUN: begin
                    if (outdate_key) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = state;
            endcase
        end
    end

    // Beats 0-3 carry the key low word first, then counter/nonce packed into two words.
    always_comb begin
        case (beat)
            3'd4:    beat_data = {nonce_r[31:0], counter_r};
            3'd5:    beat_data = {nonce_r[95:64], nonce_r[63:32]};
            default: beat_data = key_r[{beat[1:0], 6'd0} +: 64];
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state            <= IDLE;
            key_r            <= '0;
            nonce_r          <= '0;
            counter_r        <= '0;
            beat             <= '0;
            timer            <= '0;
            init_data_finish <= 1'b0;
            key_stale        <= 1'b0;
            cfg_err          <= 1'b0;
            err_code         <= 2'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                key_r            <= cfg_key;
                nonce_r          <= cfg_nonce;
                counter_r        <= cfg_counter;
                beat             <= '0;
                timer            <= '0;
                init_data_finish <= 1'b0;
                key_stale        <= 1'b0;
                cfg_err          <= 1'b0;
                err_code         <= 2'd0;
            end else begin
                if (busy) begin
                    timer <= (handshake || err_hit) ? 8'd0 : timer + 8'd1;
                end
                if (beat_ok) begin
                    beat <= beat + 3'd1;
                end
                if (last_ok) begin
                    init_data_finish <= 1'b1;
                end
                if (err_hit) begin
                    cfg_err  <= 1'b1;
                    err_code <= err_next;
                end
                if ((state == RUN) && outdate_key) begin
                    init_data_finish <= 1'b0;
                    key_stale        <= 1'b1;
                end
            end
        end
    end

    // Bus outputs decode straight from the registered state so a reset silences them at once.
    assign cfg_ready     = ready_state && !areset;
    assign m_axi_awvalid = (state == AW);
    assign m_axi_awaddr  = (state == AW) ? {57'd0, beat, 4'd0} : 64'd0;
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awid    = ID;
    assign m_axi_wvalid  = (state == W);
    assign m_axi_wlast   = (state == W);
    assign m_axi_wdata   = (state == W) ? beat_data : 64'd0;
    assign m_axi_bready  = (state == B);

endmodule

// File: tb/tb_chacha20_cfg_sequencer.sv
// Directed bench for chacha20_cfg_sequencer: a small AXI write slave with selectable
// misbehaviour, a handshake monitor, and hand-computed expected beats.
module tb_chacha20_cfg_sequencer;
    localparam int IDW     = 4;
    localparam int CFG_ID  = 3;
    localparam int TIMEOUT = 255;

    localparam int M_OK     = 0;
    localparam int M_STALL  = 1;
    localparam int M_BRESP  = 2;
    localparam int M_AWHANG = 3;
    localparam int M_BADID  = 4;

    localparam logic [255:0] KEY   = 256'h1f1e1d1c1b1a191817161514131211100f0e0d0c0b0a09080706050403020100;
    localparam logic [95:0]  NONCE = 96'h000000004a00000000000000;
    localparam logic [31:0]  CTR   = 32'h00000001;

    logic           aclk = 1'b0;
    logic           areset;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [255:0]   cfg_key;
    logic [95:0]    cfg_nonce;
    logic [31:0]    cfg_counter;
    logic           m_axi_awvalid;
    logic           m_axi_awready;
    logic [63:0]    m_axi_awaddr;
    logic [7:0]     m_axi_awlen;
    logic [IDW-1:0] m_axi_awid;
    logic           m_axi_wvalid;
    logic           m_axi_wready;
    logic           m_axi_wlast;
    logic [63:0]    m_axi_wdata;
    logic           m_axi_bvalid;
    logic           m_axi_bready;
    logic [IDW-1:0] m_axi_bid;
    logic [1:0]     m_axi_bresp;
    logic           init_data_finish;
    logic           outdate_key;
    logic           key_stale;
    logic           cfg_err;
    logic [1:0]     err_code;

    chacha20_cfg_sequencer #(
        .AXI_IDWIDTH(IDW),
        .CFG_ID     (CFG_ID),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .aclk            (aclk),
        .areset          (areset),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_key         (cfg_key),
        .cfg_nonce       (cfg_nonce),
        .cfg_counter     (cfg_counter),
        .m_axi_awvalid   (m_axi_awvalid),
        .m_axi_awready   (m_axi_awready),
        .m_axi_awaddr    (m_axi_awaddr),
        .m_axi_awlen     (m_axi_awlen),
        .m_axi_awid      (m_axi_awid),
        .m_axi_wvalid    (m_axi_wvalid),
        .m_axi_wready    (m_axi_wready),
        .m_axi_wlast     (m_axi_wlast),
        .m_axi_wdata     (m_axi_wdata),
        .m_axi_bvalid    (m_axi_bvalid),
        .m_axi_bready    (m_axi_bready),
        .m_axi_bid       (m_axi_bid),
        .m_axi_bresp     (m_axi_bresp),
        .init_data_finish(init_data_finish),
        .outdate_key     (outdate_key),
        .key_stale       (key_stale),
        .cfg_err         (cfg_err),
        .err_code        (err_code)
    );

    always #5 aclk = ~aclk;

    int          check_cnt = 0;
    int          pass_cnt  = 0;
    int          mode      = M_OK;
    int          overlap_cnt = 0;
    int          stable_viol = 0;
    logic [63:0] aw_q[$];
    logic [63:0] w_q[$];
    logic [63:0] exp_data [6];
    logic [63:0] last_awaddr = '0;
    logic [63:0] prev_awaddr = '0;
    logic [63:0] prev_wdata  = '0;
    bit          prev_aw_stall = 0;
    bit          prev_w_stall  = 0;
    bit          aw_fire = 0, w_fire = 0, b_fire = 0, rst_seen = 0;
    bit          pending_b = 0;
    int          aw_wait = 0, w_wait = 0, b_wait = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        check_cnt++;
        if (observed === expected) pass_cnt++;
        else $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    // Offers one configuration and returns #1 after the edge on which it was accepted.
    task automatic applyStimulus(input logic [255:0] key, input logic [95:0] nonce, input logic [31:0] ctr);
        bit done;
        done        = 1'b0;
        cfg_key     = key;
        cfg_nonce   = nonce;
        cfg_counter = ctr;
        cfg_valid   = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            done = cfg_ready;
            @(posedge aclk); #1;
        end
        cfg_valid = 1'b0;
        if (!done) checkOutput("cfg_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic waitFor(input int which, input int limit, output int cycles);
        bit hit;
        hit    = 1'b0;
        cycles = 0;
        while (!hit && cycles < limit) begin
            @(posedge aclk); #1;
            cycles++;
            case (which)
                0:       hit = init_data_finish;
                1:       hit = cfg_err;
                default: hit = m_axi_wvalid && (aw_q.size() == 3);
            endcase
        end
        if (!hit) checkOutput($sformatf("wait%0d_timeout", which), 64'd0, 64'd1);
    endtask

    task automatic checkWrites(input int n, input string tag);
        checkOutput({tag, "_aw_count"}, 64'(aw_q.size()), 64'(n));
        checkOutput({tag, "_w_count"}, 64'(w_q.size()), 64'(n));
        for (int i = 0; i < n && i < aw_q.size() && i < w_q.size(); i++) begin
            checkOutput($sformatf("%s_addr%0d", tag, i), aw_q[i], 64'(i * 16));
            checkOutput($sformatf("%s_data%0d", tag, i), w_q[i], exp_data[i]);
        end
    endtask

    task automatic clearQueues();
        aw_q.delete();
        w_q.delete();
    endtask

    // Monitor: records handshakes that complete on the following rising edge.
    initial begin
        forever begin
            @(negedge aclk);
            rst_seen = areset;
            aw_fire  = !areset && m_axi_awvalid && m_axi_awready;
            w_fire   = !areset && m_axi_wvalid && m_axi_wready;
            b_fire   = !areset && m_axi_bvalid && m_axi_bready;
            if (aw_fire) begin
                aw_q.push_back(m_axi_awaddr);
                last_awaddr = m_axi_awaddr;
            end
            if (w_fire) w_q.push_back(m_axi_wdata);
            if ((int'(m_axi_awvalid) + int'(m_axi_wvalid) + int'(m_axi_bready)) > 1) overlap_cnt++;
            if (prev_aw_stall && !(m_axi_awvalid && m_axi_awaddr == prev_awaddr)) stable_viol++;
            if (prev_w_stall && !(m_axi_wvalid && m_axi_wdata == prev_wdata)) stable_viol++;
            prev_aw_stall = !areset && m_axi_awvalid && !m_axi_awready;
            prev_w_stall  = !areset && m_axi_wvalid && !m_axi_wready;
            prev_awaddr   = m_axi_awaddr;
            prev_wdata    = m_axi_wdata;
        end
    end

    // Slave: drives ready/response #1 after each rising edge.
    initial begin
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_bid     = '0;
        m_axi_bresp   = 2'b00;
        forever begin
            @(posedge aclk); #1;
            if (rst_seen) begin
                pending_b = 0;
                aw_wait   = 0;
                w_wait    = 0;
                b_wait    = 0;
            end
            if (aw_fire) aw_wait = (mode == M_STALL) ? int'($urandom_range(0, 5)) : 0;
            else if (m_axi_awvalid && aw_wait > 0) aw_wait--;
            if (w_fire) w_wait = (mode == M_STALL) ? int'($urandom_range(0, 5)) : 0;
            else if (m_axi_wvalid && w_wait > 0) w_wait--;
            if (b_fire) pending_b = 0;
            if (w_fire && !rst_seen) begin
                pending_b = 1;
                b_wait    = (mode == M_STALL) ? int'($urandom_range(0, 5)) : 0;
            end else if (pending_b && b_wait > 0) begin
                b_wait--;
            end
            m_axi_awready = (mode != M_AWHANG) && (mode != M_STALL || aw_wait == 0);
            m_axi_wready  = (mode != M_STALL) || (w_wait == 0);
            m_axi_bvalid  = pending_b && ((mode != M_STALL) || (b_wait == 0));
            m_axi_bresp   = (mode == M_BRESP && last_awaddr == 64'h30) ? 2'b10 : 2'b00;
            m_axi_bid     = (mode == M_BADID) ? IDW'(CFG_ID + 1) : IDW'(CFG_ID);
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed no completion expected completion before 1000000 ns");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        exp_data[0] = 64'h0706050403020100;
        exp_data[1] = 64'h0f0e0d0c0b0a0908;
        exp_data[2] = 64'h1716151413121110;
        exp_data[3] = 64'h1f1e1d1c1b1a1918;
        exp_data[4] = 64'h0000000000000001;
        exp_data[5] = 64'h000000004a000000;
        areset      = 1'b1;
        cfg_valid   = 1'b0;
        cfg_key     = '0;
        cfg_nonce   = '0;
        cfg_counter = '0;
        outdate_key = 1'b0;

        repeat (3) @(posedge aclk);
        #1;
        checkOutput("rst_cfg_ready", 64'(cfg_ready), 64'd0);
        checkOutput("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
        checkOutput("rst_wvalid", 64'(m_axi_wvalid), 64'd0);
        checkOutput("rst_bready", 64'(m_axi_bready), 64'd0);
        checkOutput("rst_init", 64'(init_data_finish), 64'd0);
        checkOutput("rst_err", 64'({cfg_err, err_code, key_stale}), 64'd0);
        checkOutput("rst_awid", 64'(m_axi_awid), 64'(CFG_ID));
        areset = 1'b0;
        @(posedge aclk); #1;
        checkOutput("ready_after_reset", 64'(cfg_ready), 64'd1);

        // Zero-wait slave: first AW one cycle after acceptance, RUN 18 edges later.
        clearQueues();
        applyStimulus(KEY, NONCE, CTR);
        checkOutput("zw_awvalid_first", 64'(m_axi_awvalid), 64'd1);
        checkOutput("zw_awaddr_first", m_axi_awaddr, 64'h0);
        checkOutput("zw_awlen", 64'(m_axi_awlen), 64'd0);
        waitFor(0, 100, cyc);
        checkOutput("zw_init_latency", 64'(cyc), 64'd18);
        checkWrites(6, "zw");
        checkOutput("zw_no_err", 64'({cfg_err, err_code, key_stale}), 64'd0);

        mode = M_STALL;
        clearQueues();
        stable_viol = 0;
        applyStimulus(KEY, NONCE, CTR);
        checkOutput("stall_init_dropped", 64'(init_data_finish), 64'd0);
        waitFor(0, 2000, cyc);
        checkWrites(6, "stall");
        checkOutput("stall_valid_stable", 64'(stable_viol), 64'd0);

        mode = M_BRESP;
        clearQueues();
        applyStimulus(KEY, NONCE, CTR);
        waitFor(1, 500, cyc);
        checkOutput("bresp_err_code", 64'(err_code), 64'd1);
        repeat (10) @(posedge aclk);
        #1;
        checkOutput("bresp_beats", 64'(aw_q.size()), 64'd4);
        checkOutput("bresp_init", 64'(init_data_finish), 64'd0);
        checkOutput("bresp_bus_idle", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 64'd0);
        checkOutput("bresp_cfg_err_sticky", 64'(cfg_err), 64'd1);

        mode = M_OK;
        clearQueues();
        applyStimulus(KEY, NONCE, CTR);
        checkOutput("recover_cfg_err_clear", 64'(cfg_err), 64'd0);
        checkOutput("recover_err_code_clear", 64'(err_code), 64'd0);
        waitFor(0, 100, cyc);
        checkWrites(6, "recover");

        mode = M_AWHANG;
        clearQueues();
        applyStimulus(KEY, NONCE, CTR);
        waitFor(1, 600, cyc);
        checkOutput("timeout_cycles", 64'(cyc), 64'(TIMEOUT + 1));
        checkOutput("timeout_err_code", 64'(err_code), 64'd3);
        checkOutput("timeout_awvalid", 64'(m_axi_awvalid), 64'd0);

        mode = M_BADID;
        clearQueues();
        applyStimulus(KEY, NONCE, CTR);
        waitFor(1, 100, cyc);
        checkOutput("badid_err_code", 64'(err_code), 64'd2);
        checkOutput("badid_beats", 64'(aw_q.size()), 64'd1);

        mode = M_OK;
        clearQueues();
        applyStimulus(KEY, NONCE, CTR);
        waitFor(0, 100, cyc);
        outdate_key = 1'b1;
        @(posedge aclk); #1;
        outdate_key = 1'b0;
        checkOutput("rekey_init", 64'(init_data_finish), 64'd0);
        checkOutput("rekey_stale", 64'(key_stale), 64'd1);
        checkOutput("rekey_idle_ready", 64'(cfg_ready), 64'd1);
        outdate_key = 1'b1;
        @(posedge aclk); #1;
        outdate_key = 1'b0;
        checkOutput("idle_outdate_ignored", 64'({key_stale, m_axi_awvalid, init_data_finish}), 64'b100);
        applyStimulus(KEY, NONCE, CTR);
        checkOutput("reload_stale_clear", 64'(key_stale), 64'd0);
        waitFor(0, 100, cyc);
        cfg_valid   = 1'b1;
        outdate_key = 1'b1;
        @(posedge aclk); #1;
        cfg_valid   = 1'b0;
        outdate_key = 1'b0;
        checkOutput("cfg_wins_stale", 64'(key_stale), 64'd0);
        checkOutput("cfg_wins_awvalid", 64'(m_axi_awvalid), 64'd1);
        checkOutput("cfg_wins_init", 64'(init_data_finish), 64'd0);
        waitFor(0, 100, cyc);

        // Reset while beat 2 sits in W, then a fresh load must start at address 0.
        clearQueues();
        applyStimulus(KEY, NONCE, CTR);
        waitFor(2, 100, cyc);
        areset = 1'b1;
        @(posedge aclk); #1;
        checkOutput("midrst_bus", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready}), 64'd0);
        checkOutput("midrst_wdata", m_axi_wdata, 64'd0);
        checkOutput("midrst_status", 64'({cfg_ready, init_data_finish, cfg_err, err_code}), 64'd0);
        checkOutput("midrst_awid", 64'(m_axi_awid), 64'(CFG_ID));
        areset = 1'b0;
        clearQueues();
        @(posedge aclk); #1;
        checkOutput("midrst_no_beats", 64'(aw_q.size()), 64'd0);
        applyStimulus(KEY, NONCE, CTR);
        waitFor(0, 100, cyc);
        checkWrites(6, "after_rst");

        checkOutput("no_channel_overlap", 64'(overlap_cnt), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
